mem_arbiter_rr: RTL

Parametrised N-port round-robin arbiter connecting picorv32-style look-ahead memory ports (mem_la_*) to one shared target bus (memory, LED, UART decode lives downstream).
Replaces fixed time-slot polling with a work-conserving rotating-priority grant.
Adds target back-pressure (multi-cycle targets) and per-port starvation flags.
Sits between the core array and the SoC address decoder.

---
 rtl/hydra_pkg.sv | 18 +
 rtl/mem_arbiter_rr_if.sv | 44 ++++
 rtl/rr_priority_pick.sv | 28 ++
 rtl/mem_arbiter_rr.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/hydra_pkg.sv
// Shared definitions for the hydra SoC arbiters: FSM encoding and width helpers.
package hydra_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits for a single-entry array.
  function automatic int clog2_floor1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Bundle of the core-side look-ahead ports and the shared target bus around the arbiter.
interface mem_arbiter_rr_if
  import hydra_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  localparam int STRB_W    = strb_width(DATA_W);
  localparam int PORT_BITS = clog2_floor1(N_PORTS);

  logic [N_PORTS-1:0]        la_read;
  logic [N_PORTS-1:0]        la_write;
  logic [N_PORTS*ADDR_W-1:0] la_addr;
  logic [N_PORTS*DATA_W-1:0] la_wdata;
  logic [N_PORTS*STRB_W-1:0] la_wstrb;
  logic [N_PORTS-1:0]        port_ready;
  logic [N_PORTS*DATA_W-1:0] port_rdata;

  logic                      tgt_valid;
  logic                      tgt_write;
  logic [ADDR_W-1:0]         tgt_addr;
  logic [DATA_W-1:0]         tgt_wdata;
  logic [STRB_W-1:0]         tgt_wstrb;
  logic [PORT_BITS-1:0]      tgt_port;
  logic                      tgt_ready;
  logic [DATA_W-1:0]         tgt_rdata;

  // Arbiter view: accepts core requests, drives the target.
  modport slave (
    input  la_read, la_write, la_addr, la_wdata, la_wstrb, tgt_ready, tgt_rdata,
    output port_ready, port_rdata,
    output tgt_valid, tgt_write, tgt_addr, tgt_wdata, tgt_wstrb, tgt_port
  );

  // Environment view: cores plus the downstream decoder/target.
  modport master (
    output la_read, la_write, la_addr, la_wdata, la_wstrb, tgt_ready, tgt_rdata,
    input  port_ready, port_rdata,
    input  tgt_valid, tgt_write, tgt_addr, tgt_wdata, tgt_wstrb, tgt_port
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set bit of 'pending' at or after 'rr_ptr', wrapping.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     pending,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any_valid
);

  logic [PTR_W-1:0] idx;

  // Scan from farthest to nearest so the closest pending index is written last.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr) + k) % N);
      if (pending[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Work-conserving round-robin arbiter from N look-ahead core ports onto one shared target bus.
module mem_arbiter_rr
  import hydra_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WAIT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_arbiter_rr_if.slave    bus,
  output logic [N_PORTS-1:0] starve
);

  localparam int STRB_W    = strb_width(DATA_W);
  localparam int PORT_BITS = clog2_floor1(N_PORTS);
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  arb_state_t           state, state_next;
  logic [PORT_BITS-1:0] rr_ptr, grant_reg, pick, ptr_after;
  logic                 any_pending, grant_now, completing;

  logic [N_PORTS-1:0]   pending, req, free, capture, done_port;
  logic                 slot_write [N_PORTS];
  logic [ADDR_W-1:0]    slot_addr  [N_PORTS];
  logic [DATA_W-1:0]    slot_wdata [N_PORTS];
  logic [STRB_W-1:0]    slot_wstrb [N_PORTS];
  logic [WAIT_W-1:0]    wait_cnt   [N_PORTS];

  assign completing = (state == ARB_BUSY) && bus.tgt_ready;
  assign grant_now  = (state == ARB_IDLE) && any_pending;

  rr_priority_pick #(
    .N     (N_PORTS),
    .PTR_W (PORT_BITS)
  ) u_pick (
    .pending   (pending),
    .rr_ptr    (rr_ptr),
    .grant     (pick),
    .any_valid (any_pending)
  );

  // A slot can accept a new request while its previous one is completing this cycle.
  always_comb begin
    req       = '0;
    free      = '0;
    capture   = '0;
    done_port = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      req[i]       = bus.la_read[i] | bus.la_write[i];
      done_port[i] = completing && (grant_reg == PORT_BITS'(i));
      free[i]      = !pending[i] || done_port[i];
      capture[i]   = req[i] && free[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        slot_write[i] <= 1'b0;
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
        slot_wstrb[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (capture[i]) begin
          slot_write[i] <= bus.la_write[i];
          slot_addr[i]  <= bus.la_addr[ADDR_W*i +: ADDR_W];
          slot_wdata[i] <= bus.la_wdata[DATA_W*i +: DATA_W];
          slot_wstrb[i] <= bus.la_wstrb[STRB_W*i +: STRB_W];
          pending[i]    <= 1'b1;
        end else if (done_port[i]) begin
          pending[i]    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (any_pending)   state_next = ARB_BUSY;
      ARB_BUSY: if (bus.tgt_ready) state_next = ARB_IDLE;
      default:                     state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    ptr_after = '0;
    if (int'(grant_reg) < N_PORTS - 1) ptr_after = grant_reg + PORT_BITS'(1);
  end

  // Target request is registered at grant and held untouched until tgt_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.tgt_valid  <= 1'b0;
      bus.tgt_write  <= 1'b0;
      bus.tgt_addr   <= '0;
      bus.tgt_wdata  <= '0;
      bus.tgt_wstrb  <= '0;
      bus.tgt_port   <= '0;
      bus.port_ready <= '0;
      bus.port_rdata <= '0;
      grant_reg      <= '0;
      rr_ptr         <= '0;
    end else begin
      bus.port_ready <= '0;
      if (grant_now) begin
        bus.tgt_valid <= 1'b1;
        bus.tgt_write <= slot_write[pick];
        bus.tgt_addr  <= slot_addr[pick];
        bus.tgt_wdata <= slot_wdata[pick];
        bus.tgt_wstrb <= slot_wstrb[pick];
        bus.tgt_port  <= pick;
        grant_reg     <= pick;
      end
      if (completing) begin
        bus.tgt_valid             <= 1'b0;
        bus.port_ready[grant_reg] <= 1'b1;
        rr_ptr                    <= ptr_after;
        if (!bus.tgt_write) bus.port_rdata[DATA_W*grant_reg +: DATA_W] <= bus.tgt_rdata;
      end
    end
  end

  // A port waits whenever it is pending but not the one currently on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PORTS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (grant_now && (pick == PORT_BITS'(i)))
          wait_cnt[i] <= '0;
        else if (pending[i] && !((state == ARB_BUSY) && (grant_reg == PORT_BITS'(i)))
                 && (wait_cnt[i] != WAIT_MAX))
          wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
      end
    end
  end

  always_comb begin
    starve = '0;
    for (int i = 0; i < N_PORTS; i++) starve[i] = (wait_cnt[i] == WAIT_MAX);
  end

  a_no_overrun: assert property (@(posedge clk) disable iff (reset) (req & ~free) == '0)
    else $error("mem_arbiter_rr: request to an occupied slot was ignored");

endmodule
